md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit in the EXE stage of the P6 pipeline.
- Produces the Busy signal that freezes the ID/EX pipeline register while a mult/div operation is in flight.
- Holds the architectural HI/LO registers.
- Implements MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency, and MTHI/MTLO with zero stall.
- HI/LO are read through HI_Out/LO_Out by the EXE result mux (MFHI/MFLO).

Parameters:
- MULT_CYCLES, 5, Busy duration in cycles for MULT/MULTU (≥1).
- DIV_CYCLES, 10, Busy duration in cycles for DIV/DIVU (≥1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- Start  input  1  one-cycle request; MDOp and operands valid when high
- MDOp  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (see Optional Feature)
- RData1_In  input  32  rs operand, already forwarded
- RData2_In  input  32  rt operand, already forwarded
- Busy  output  1  registered; high while an operation is in progress
- HI_Out  output  32  current HI
- LO_Out  output  32  current LO

Behaviour:
- Reset (reset=0, async): Busy=0, HI=0, LO=0, counter=0, pending result cleared, state IDLE.
- Reset mid-operation: the operation is discarded and HI/LO go to 0 immediately.
- States: IDLE and RUN.
- IDLE, Start=1 at edge T, MDOp in 0..3:
  - latch operands and op, compute the 64-bit result into a pending register;
  - load counter with N (MULT_CYCLES for ops 0/1, DIV_CYCLES for ops 2/3);
  - go to RUN.
  - Busy=1 for cycles T+1 .. T+N.
- RUN: counter decrements each edge. On the edge where counter==1:
  - commit pending result to HI/LO;
  - Busy goes 0 and state returns to IDLE.
  - New HI/LO are visible in the same cycle Busy first reads 0.
- IDLE, Start=1, MDOp 4/5: HI (MTHI) or LO (MTLO) <= RData1_In at that edge; Busy stays 0.
- Start while Busy=1: ignored entirely. The hazard unit must stall with Start|Busy; the unit does not queue requests.
- Start with MDOp 6/7 and the feature disabled: ignored, no state change.
- MULT: {HI,LO} = signed(rs)*signed(rt), full 64-bit result.
- MULTU: same, unsigned.
- DIV: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (rt==0):
  - full Busy duration still applies;
  - HI/LO are left unchanged at commit.
- Operands are sampled at the Start edge only. Later changes on RData*_In during RUN have no effect.
- HI_Out/LO_Out are direct register outputs with no internal bypass. MFHI during Busy is the hazard unit's responsibility (stall).

Optional Feature:
- Macro MD_MADD_EN.
- Defined: MDOp 6 = MADD and MDOp 7 = MADDU.
  - Result: {HI,LO} <= {HI,LO} + rs*rt, signed/unsigned product respectively, 64-bit wrap-around.
  - Latency is MULT_CYCLES.
  - The accumulate source is HI/LO as of commit time; HI/LO cannot change during RUN, so this equals the Start-time value.
- Undefined: MDOp 6/7 are ignored as reserved; no extra adder logic.

Test Plan:
- Reset release, then Start MULT with rs=0xFFFFFFFF, rt=2 -> Busy=1 for exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV with rs=0xFFFFFFF9 (-7), rt=2 -> Busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with rs=7, rt=2 -> LO=3, HI=1.
- MTHI with rs=0x12345678, then DIV with rt=0 -> Busy for 10 cycles; HI still 0x12345678 and LO unchanged afterwards.
- Start a MULT, then drive a second Start (DIV) on cycle 2 of Busy -> second Start ignored; Busy drops after 5 cycles total; only the MULT result is committed.
- Start a DIV, drive reset=0 asynchronously (mid-cycle) on cycle 4 -> Busy, HI and LO go 0 immediately without waiting for a clock edge; after release, no late commit occurs.
- With MD_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU rs=1, rt=1 -> HI=1, LO=0 after 5 cycles.

Source files
------------

// File: rtl/md_unit_if.sv
// Request/response bundle between the EXE stage and the multiply/divide unit.
// The pipeline side drives Start/MDOp/operands; the unit returns Busy and HI/LO.
interface md_unit_if;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] RData1_In;
  logic [31:0] RData2_In;
  logic        Busy;
  logic [31:0] HI_Out;
  logic [31:0] LO_Out;

  modport master (
    output Start, MDOp, RData1_In, RData2_In,
    input  Busy, HI_Out, LO_Out
  );

  modport slave (
    input  Start, MDOp, RData1_In, RData2_In,
    output Busy, HI_Out, LO_Out
  );
endinterface

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit: MULT*/DIV* busy for MULT_CYCLES/DIV_CYCLES then commit, MTHI/MTLO same edge.
// No queueing: Start while Busy is dropped. MD_MADD_EN adds MADD/MADDU on MDOp 6/7.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic   clk,
  input logic   reset,
  md_unit_if.slave md
);
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MD_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic        commit_q, commit_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
`ifdef MD_MADD_EN
  logic        acc_q, acc_d;
`endif

  logic [31:0] rs, rt;
  logic [63:0] prod_s, prod_u;
  logic        rt_nz, div_ovf;
  logic [31:0] rt_div;
  logic signed [31:0] rs_sg, rt_sg, sq_raw, sr_raw;
  logic [31:0] squo, srem, uquo, urem;

  // Arithmetic on the live operands; only the Start edge captures it.
  always_comb begin
    rs      = md.RData1_In;
    rt      = md.RData2_In;
    prod_s  = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    prod_u  = {32'd0, rs} * {32'd0, rt};
    rt_nz   = (rt != 32'd0);
    // -2^31 / -1 overflows; it is resolved explicitly and the divider sees 1.
    div_ovf = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);
    rt_div  = (!rt_nz || div_ovf) ? 32'd1 : rt;
    rs_sg   = rs;
    rt_sg   = rt_div;
    sq_raw  = rs_sg / rt_sg;
    sr_raw  = rs_sg % rt_sg;
    squo    = div_ovf ? 32'h8000_0000 : sq_raw;
    srem    = div_ovf ? 32'd0 : sr_raw;
    uquo    = rs / rt_div;
    urem    = rs % rt_div;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    commit_d = commit_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MD_MADD_EN
    acc_d    = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (md.Start) begin
          case (md.MDOp)
            OP_MULT, OP_MULTU: begin
              pend_d   = (md.MDOp == OP_MULT) ? prod_s : prod_u;
              commit_d = 1'b1;
              cnt_d    = CNT_W'(MULT_CYCLES);
              state_d  = RUN;
`ifdef MD_MADD_EN
              acc_d    = 1'b0;
`endif
            end
            OP_DIV, OP_DIVU: begin
              pend_d   = (md.MDOp == OP_DIV) ? {srem, squo} : {urem, uquo};
              commit_d = rt_nz;
              cnt_d    = CNT_W'(DIV_CYCLES);
              state_d  = RUN;
`ifdef MD_MADD_EN
              acc_d    = 1'b0;
`endif
            end
            OP_MTHI: hi_d = rs;
            OP_MTLO: lo_d = rs;
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU: begin
              pend_d   = (md.MDOp == OP_MADD) ? prod_s : prod_u;
              commit_d = 1'b1;
              acc_d    = 1'b1;
              cnt_d    = CNT_W'(MULT_CYCLES);
              state_d  = RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (commit_q) begin
`ifdef MD_MADD_EN
            {hi_d, lo_d} = pend_q + (acc_q ? {hi_q, lo_q} : 64'd0);
`else
            {hi_d, lo_d} = pend_q;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_q   <= '0;
      commit_q <= 1'b0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MD_MADD_EN
      acc_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      commit_q <= commit_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MD_MADD_EN
      acc_q    <= acc_d;
`endif
    end
  end

  assign md.Busy   = busy_q;
  assign md.HI_Out = hi_q;
  assign md.LO_Out = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: vector table of single ops plus hand sequences for ignored Start and async reset.
module tb_md_unit;
  logic clk;
  logic reset;
  md_unit_if md_if();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vt[24];
  int   nv = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                     input int cyc, input logic [31:0] hi, input logic [31:0] lo);
    vt[nv].op  = op;
    vt[nv].rs  = rs;
    vt[nv].rt  = rt;
    vt[nv].cyc = cyc;
    vt[nv].hi  = hi;
    vt[nv].lo  = lo;
    nv++;
  endtask

  // Issue one op, scramble operands afterwards, count Busy cycles (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        output int nbusy);
    @(negedge clk);
    md_if.Start     = 1'b1;
    md_if.MDOp      = op;
    md_if.RData1_In = rs;
    md_if.RData2_In = rt;
    @(negedge clk);
    md_if.Start     = 1'b0;
    md_if.RData1_In = $urandom;
    md_if.RData2_In = $urandom;
    nbusy = 0;
    while (md_if.Busy && nbusy < 50) begin
      nbusy++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    reset = 1'b0;
    md_if.Start = 1'b0;
    md_if.MDOp = 3'd0;
    md_if.RData1_In = '0;
    md_if.RData2_In = '0;

    add(3'd0, 32'hFFFF_FFFF, 32'd2,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    add(3'd1, 32'hFFFF_FFFF, 32'd2,        5,  32'h0000_0001, 32'hFFFF_FFFE);
    add(3'd2, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    add(3'd3, 32'd7,         32'd2,        10, 32'd1,         32'd3);
    add(3'd4, 32'h1234_5678, 32'd0,        0,  32'h1234_5678, 32'd3);
    add(3'd2, 32'd5,         32'd0,        10, 32'h1234_5678, 32'd3);
    add(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,        32'h8000_0000);
    add(3'd5, 32'hDEAD_BEEF, 32'd9,        0,  32'd0,         32'hDEAD_BEEF);
    add(3'd0, 32'hFFFF_FFFD, 32'd7,        5,  32'hFFFF_FFFF, 32'hFFFF_FFEB);
    add(3'd2, 32'd7,         32'hFFFF_FFFE, 10, 32'd1,        32'hFFFF_FFFD);
    add(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    add(3'd3, 32'hFFFF_FFFF, 32'h10,       10, 32'hF,         32'h0FFF_FFFF);
    add(3'd4, 32'd0,         32'd0,        0,  32'd0,         32'h0FFF_FFFF);
    add(3'd5, 32'hFFFF_FFFF, 32'd0,        0,  32'd0,         32'hFFFF_FFFF);
`ifdef MD_MADD_EN
    add(3'd7, 32'd1,         32'd1,        5,  32'd1,         32'd0);
    add(3'd6, 32'hFFFF_FFFF, 32'd1,        5,  32'd0,         32'hFFFF_FFFF);
`else
    add(3'd7, 32'd1,         32'd1,        0,  32'd0,         32'hFFFF_FFFF);
    add(3'd6, 32'hFFFF_FFFF, 32'd1,        0,  32'd0,         32'hFFFF_FFFF);
`endif

    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, md_if.Busy}, 32'd0);
    check("reset_hi", md_if.HI_Out, 32'd0);
    check("reset_lo", md_if.LO_Out, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_busy", {31'd0, md_if.Busy}, 32'd0);

    for (int i = 0; i < nv; i++) begin
      run_op(vt[i].op, vt[i].rs, vt[i].rt, n);
      check($sformatf("v%0d_busy_cycles", i), 32'(n), 32'(vt[i].cyc));
      check($sformatf("v%0d_hi", i), md_if.HI_Out, vt[i].hi);
      check($sformatf("v%0d_lo", i), md_if.LO_Out, vt[i].lo);
    end

    // MULT 3*4, then a DIV request on the second Busy cycle must be dropped.
    @(negedge clk);
    md_if.Start = 1'b1;
    md_if.MDOp = 3'd0;
    md_if.RData1_In = 32'd3;
    md_if.RData2_In = 32'd4;
    @(negedge clk);
    md_if.Start = 1'b0;
    n = 0;
    while (md_if.Busy && n < 50) begin
      n++;
      md_if.Start = (n == 2);
      md_if.MDOp = 3'd2;
      md_if.RData1_In = 32'd100;
      md_if.RData2_In = 32'd7;
      @(negedge clk);
    end
    md_if.Start = 1'b0;
    check("ign_busy_cycles", 32'(n), 32'd5);
    check("ign_hi", md_if.HI_Out, 32'd0);
    check("ign_lo", md_if.LO_Out, 32'd12);
    repeat (12) @(negedge clk);
    check("ign_late_busy", {31'd0, md_if.Busy}, 32'd0);
    check("ign_late_hi", md_if.HI_Out, 32'd0);
    check("ign_late_lo", md_if.LO_Out, 32'd12);

    // DIV interrupted by an asynchronous reset partway through a cycle.
    @(negedge clk);
    md_if.Start = 1'b1;
    md_if.MDOp = 3'd3;
    md_if.RData1_In = 32'd100;
    md_if.RData2_In = 32'd7;
    @(negedge clk);
    md_if.Start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pre_busy", {31'd0, md_if.Busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_async_busy", {31'd0, md_if.Busy}, 32'd0);
    check("rst_async_hi", md_if.HI_Out, 32'd0);
    check("rst_async_lo", md_if.LO_Out, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("rst_late_busy", {31'd0, md_if.Busy}, 32'd0);
    check("rst_late_hi", md_if.HI_Out, 32'd0);
    check("rst_late_lo", md_if.LO_Out, 32'd0);

    // Unit still operates normally after the aborted op.
    run_op(3'd3, 32'd100, 32'd7, n);
    check("after_rst_busy_cycles", 32'(n), 32'd10);
    check("after_rst_hi", md_if.HI_Out, 32'd2);
    check("after_rst_lo", md_if.LO_Out, 32'd14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
